uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial receiver, the companion stage to the UART transmitter. Consumes an 8N1 line (idle high,
//  LSB first) and samples it on a 16x oversampling tick from an internal programmable divider.
//  Received bytes are buffered in a small FIFO and read through the same 3-bit address /
//  8-bit data bus used by the transmitter. Typically wired to an off-chip RX pin or looped
//  back from the transmitter's txout.
// PARAMETERS
//  PERIOD      8'h1A  reset value of the divider register; tick every PERIOD+1 clk
//  FIFO_DEPTH  4      receive FIFO entries; power of 2, minimum 2
// PORTS
//  clk     in   1  system clock
//  reset   in   1  asynchronous, active-high reset
//  wren    in   1  bus write strobe, one clk per access
//  rden    in   1  bus read strobe, one clk per access
//  addr    in   3  register select: 000 PERIOD, 010 RXDATA, 011 STATUS
//  din     in   8  bus write data
//  dout    out  8  bus read data; combinational from addr/rden
//  rxin    in   1  asynchronous serial input
//  rx_irq  out  1  high while FIFO not empty
// BEHAVIOUR
//  Reset: period=PERIOD, divider=0, FSM IDLE, FIFO empty, flags 0, rx sync regs=1, rx_irq=0.
//   dout=0 whenever rden=0.
//  Sync: rxin passes through 2 flops; all decisions use the synced value (2 clk latency).
//  Divider: 8-bit counter counts 0..period; when equal to period, tick=1 for one clk and
//   counter wraps to 0. period=0 gives a tick every clk. Bit time = 16*(period+1) clk.
//   A write to 000 loads period from din and clears the counter. A read of 000 returns period.
//  FSM (advances only on tick, except IDLE->START); 4-bit sample count sc, 3-bit bit index bi:
//   IDLE : synced rx==0 -> START, sc=0.
//   START: sc++ each tick. When sc==7: rx==0 -> DATA, sc=0, bi=0. rx==1 -> IDLE (glitch, no flag).
//   DATA : sc++ each tick. When sc==15: shift rx into MSB of the shift register
//    (LSB arrives first), sc=0. bi==7 -> STOP, else bi++.
//   STOP : sc++ each tick. When sc==15, evaluate:
//    - rx==1 and space available -> push byte.
//    - rx==0 -> set FRAMERR, discard byte.
//    - rx==1 and FIFO full -> set OVERRUN, discard byte.
//    Then -> IDLE. Return to IDLE at mid-stop-bit; a start edge is accepted on the next cycle.
//  FIFO: push and pop in the same clk are both performed. "Space available" = not full OR a pop
//   in the same clk. Pointers wrap modulo FIFO_DEPTH; occupancy counter is 0..FIFO_DEPTH.
//  RXDATA (010) read: dout = FIFO head. rden pops on that clk edge. Empty -> dout=0x00, no pop,
//   no flag. Writes to 010 are ignored.
//  STATUS (011) read: {4'b0, FRAMERR, OVERRUN, FULL, ~empty}.
//   Write: din[2]=1 clears OVERRUN, din[3]=1 clears FRAMERR (write-1-to-clear).
//   If a clear and a set hit the same clk, set wins.
//  Unmapped addresses: reads return 0x00, writes are ignored.
//  Reset mid-frame: frame abandoned, FIFO flushed, no flags set; after release, waits for the
//   next falling edge.
// TESTING
//  1 period=0, rxin sends 0xA5 (16 clk/bit) -> STATUS=0x01, rx_irq=1; read 010 -> 0xA5;
//    then STATUS=0x00, rx_irq=0.
//  2 rxin low for 5 clk, then high -> FSM back to IDLE, STATUS=0x00, no byte pushed.
//  3 send 0x3C with stop bit=0 -> STATUS=0x08, FIFO empty; write 0x08 to 011 -> STATUS=0x00.
//  4 send 0x01..0x05 with no reads (depth 4) -> STATUS=0x07 after byte 5;
//    reads return 01,02,03,04, then 0x00.
//  5 rxin=uart_tx txout, both period 0x1A; write 0x55,0x00,0xFF to TX -> RX reads 55,00,FF
//    with no flags.
//  6 assert reset at bi=3 of a frame; release and send 0x81 -> only 0x81 read; period back to 0x1A.

Source files
------------

// File: rtl/uart_rx_if.sv
// Register bus shared with the UART transmitter: 3-bit address and 8-bit data, one-clk strobes.
// dout is combinational from addr/rden on the slave side.
interface uart_rx_if;
    logic       wren;
    logic       rden;
    logic [2:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (
        output wren,
        output rden,
        output addr,
        output din,
        input  dout
    );

    modport slave (
        input  wren,
        input  rden,
        input  addr,
        input  din,
        output dout
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a 16x oversampling programmable divider and a small receive FIFO.
// Bytes and status are read through the shared 3-bit address / 8-bit data register bus.
module uart_rx #(
    parameter logic [7:0]  Period    = 8'h1A,
    parameter int unsigned FifoDepth = 4
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.slave  bus,
    input  logic      rxin_i,
    output logic      rx_irq_o
);

    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW = $clog2(FifoDepth + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(FifoDepth);

    localparam logic [2:0] AddrPeriod = 3'b000;
    localparam logic [2:0] AddrData   = 3'b010;
    localparam logic [2:0] AddrStatus = 3'b011;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic            rx_s1_q, rx_s2_q;
    logic            rx_sync;
    logic [7:0]      period_q, div_q;
    logic            tick;
    state_e          state_q;
    logic [3:0]      sc_q;
    logic [2:0]      bi_q;
    logic [7:0]      shift_q;
    logic [7:0]      mem_q [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic            empty, full;
    logic            push, pop;
    logic            stop_eval;
    logic            fe_q, ovr_q;
    logic            fe_set, ovr_set;
    logic            wr_period, wr_status, rd_data;

    assign wr_period = bus.wren && (bus.addr == AddrPeriod);
    assign wr_status = bus.wren && (bus.addr == AddrStatus);
    assign rd_data   = bus.rden && (bus.addr == AddrData);

    // Two-flop synchroniser; idles high so reset never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rxin_i;
            rx_s2_q <= rx_s1_q;
        end
    end
    assign rx_sync = rx_s2_q;

    assign tick = (div_q == period_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_q <= Period;
            div_q    <= 8'd0;
        end else if (wr_period) begin
            period_q <= bus.din;
            div_q    <= 8'd0;
        end else if (tick) begin
            div_q    <= 8'd0;
        end else begin
            div_q    <= div_q + 8'd1;
        end
    end

    // Start is confirmed at mid-bit (8 ticks); data and stop are sampled every 16 ticks after.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            sc_q    <= 4'd0;
            bi_q    <= 3'd0;
            shift_q <= 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_sync) begin
                        state_q <= StStart;
                        sc_q    <= 4'd0;
                    end
                end
                StStart: begin
                    if (tick) begin
                        if (sc_q == 4'd7) begin
                            if (!rx_sync) begin
                                state_q <= StData;
                                sc_q    <= 4'd0;
                                bi_q    <= 3'd0;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else begin
                            sc_q <= sc_q + 4'd1;
                        end
                    end
                end
                StData: begin
                    if (tick) begin
                        if (sc_q == 4'd15) begin
                            shift_q <= {rx_sync, shift_q[7:1]};
                            sc_q    <= 4'd0;
                            if (bi_q == 3'd7) begin
                                state_q <= StStop;
                            end else begin
                                bi_q <= bi_q + 3'd1;
                            end
                        end else begin
                            sc_q <= sc_q + 4'd1;
                        end
                    end
                end
                StStop: begin
                    if (tick) begin
                        if (sc_q == 4'd15) begin
                            state_q <= StIdle;
                            sc_q    <= 4'd0;
                        end else begin
                            sc_q <= sc_q + 4'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign stop_eval = (state_q == StStop) && tick && (sc_q == 4'd15);

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FullCnt);
    assign pop   = rd_data && !empty;
    // A same-clk pop frees a slot, so a full FIFO can still accept the byte.
    assign push    = stop_eval && rx_sync && (!full || pop);
    assign ovr_set = stop_eval && rx_sync && full && !pop;
    assign fe_set  = stop_eval && !rx_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // Write-1-to-clear; a set in the same clk wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fe_q  <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            fe_q  <= fe_set  | (fe_q  & ~(wr_status & bus.din[3]));
            ovr_q <= ovr_set | (ovr_q & ~(wr_status & bus.din[2]));
        end
    end

    always_comb begin
        bus.dout = 8'h00;
        if (bus.rden) begin
            case (bus.addr)
                AddrPeriod: bus.dout = period_q;
                AddrData:   bus.dout = empty ? 8'h00 : mem_q[rd_ptr_q];
                AddrStatus: bus.dout = {4'b0000, fe_q, ovr_q, full, ~empty};
                default:    bus.dout = 8'h00;
            endcase
        end
    end

    assign rx_irq_o = !empty;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames are driven from tasks, expected bytes go into a scoreboard
// queue and are compared as RXDATA is read back; status is checked against a small flag model.
module tb_uart_rx;

    logic clk = 1'b0;
    logic reset;
    logic rxin;
    logic rx_irq;

    always #5 clk = ~clk;

    uart_rx_if bus ();

    uart_rx #(
        .Period    (8'h1A),
        .FifoDepth (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .rxin_i   (rxin),
        .rx_irq_o (rx_irq)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] sb [$];
    logic       exp_fe = 1'b0;
    logic       exp_ovr = 1'b0;
    logic [7:0] rd;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, want 0x%02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_status();
        return {4'b0000, exp_fe, exp_ovr, sb.size() == 4, sb.size() != 0};
    endfunction

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.wren = 1'b1;
        bus.addr = a;
        bus.din  = d;
        @(negedge clk);
        bus.wren = 1'b0;
        if (a == 3'b011) begin
            if (d[3]) exp_fe = 1'b0;
            if (d[2]) exp_ovr = 1'b0;
        end
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.rden = 1'b1;
        bus.addr = a;
        #1 d = bus.dout;
        @(negedge clk);
        bus.rden = 1'b0;
    endtask

    task automatic check_status(input string tag);
        logic [7:0] d;
        bus_read(3'b011, d);
        check_eq(tag, d, exp_status());
    endtask

    task automatic check_irq(input string tag);
        @(negedge clk);
        check_eq(tag, {7'b0, rx_irq}, {7'b0, sb.size() != 0});
    endtask

    task automatic read_rx(input string tag);
        logic [7:0] d;
        logic [7:0] e;
        bus_read(3'b010, d);
        e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
        check_eq(tag, d, e);
    endtask

    // Drives one full frame, then an idle bit time; the model records the expected outcome.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int bit_clks);
        if (!stop_bit) exp_fe = 1'b1;
        else if (sb.size() >= 4) exp_ovr = 1'b1;
        else sb.push_back(data);
        @(negedge clk);
        rxin = 1'b0;
        repeat (bit_clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxin = data[i];
            repeat (bit_clks) @(negedge clk);
        end
        rxin = stop_bit;
        repeat (bit_clks) @(negedge clk);
        rxin = 1'b1;
        repeat (bit_clks) @(negedge clk);
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not end, got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        rxin     = 1'b1;
        bus.wren = 1'b0;
        bus.rden = 1'b0;
        bus.addr = 3'b000;
        bus.din  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        bus_read(3'b000, rd);
        check_eq("reset_period", rd, 8'h1A);
        check_status("reset_status");
        check_irq("reset_irq");

        bus_write(3'b000, 8'h00);
        bus_read(3'b000, rd);
        check_eq("period_wr", rd, 8'h00);

        // Single byte at 16 clk/bit
        send_frame(8'hA5, 1'b1, 16);
        check_status("t1_status_full");
        check_irq("t1_irq_high");
        read_rx("t1_data");
        check_status("t1_status_empty");
        check_irq("t1_irq_low");

        // Short low glitch must not start a frame
        @(negedge clk);
        rxin = 1'b0;
        repeat (5) @(negedge clk);
        rxin = 1'b1;
        repeat (40) @(negedge clk);
        check_status("t2_status");
        read_rx("t2_empty_read");

        // Framing error, then write-1-to-clear
        send_frame(8'h3C, 1'b0, 16);
        check_status("t3_fe_status");
        read_rx("t3_no_byte");
        bus_write(3'b011, 8'h08);
        check_status("t3_fe_cleared");

        // Overrun on a full FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 16);
        check_status("t4_overrun");
        for (int i = 0; i < 4; i++) read_rx("t4_data");
        read_rx("t4_empty_read");
        bus_write(3'b011, 8'h04);
        check_status("t4_ovr_cleared");

        // Unmapped and read-only locations
        bus_read(3'b001, rd);
        check_eq("unmapped_1", rd, 8'h00);
        bus_read(3'b111, rd);
        check_eq("unmapped_7", rd, 8'h00);
        bus_write(3'b010, 8'h5A);
        check_status("rxdata_wr_ignored");

        // Nominal divider: 16*(0x1A+1) = 432 clk per bit
        bus_write(3'b000, 8'h1A);
        send_frame(8'h55, 1'b1, 432);
        send_frame(8'h00, 1'b1, 432);
        send_frame(8'hFF, 1'b1, 432);
        check_status("t5_status");
        for (int i = 0; i < 3; i++) read_rx("t5_data");
        check_status("t5_status_empty");

        // Reset mid-frame at bit index 3; period also goes back to its reset value
        bus_write(3'b000, 8'h07);
        @(negedge clk);
        rxin = 1'b0;
        repeat (128 + 3 * 128 + 64) @(negedge clk);
        reset = 1'b1;
        rxin  = 1'b1;
        sb.delete();
        exp_fe  = 1'b0;
        exp_ovr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bus_read(3'b000, rd);
        check_eq("t6_period", rd, 8'h1A);
        check_status("t6_status");
        send_frame(8'h81, 1'b1, 432);
        read_rx("t6_data");
        read_rx("t6_empty_read");
        check_status("t6_status_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
